// File: rtl/systolic_master_sender_pkg.sv
// Shared hyper-parameters and state encoding for the systolic master sender.
package systolic_master_sender_pkg;

    localparam int SYS_DATA_WIDTH      = 64;
    localparam int SYSTOLIC_UNIT_NUM   = 16;
    localparam int FINAL_FMAPS_CHNNLS  = 384;
    localparam int SYS_SLICES_PER_LINE = FINAL_FMAPS_CHNNLS / SYSTOLIC_UNIT_NUM;
    localparam int CREDIT_W            = 4;

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_WAIT_CREDIT = 2'd1,
        S_SEND        = 2'd2,
        S_DRAIN       = 2'd3
    } senderState_t;

    // Counter width for a modulus of n, never narrower than 1 bit.
    function automatic int cntWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sender_credit_counter.sv
// Up/down credit counter: a simultaneous take and return leaves the count
// unchanged; a return with nothing outstanding is flagged (sticky).
module sender_credit_counter
    import systolic_master_sender_pkg::*;
#(
    parameter int CNT_W = CREDIT_W,
    parameter int LIMIT = 4
) (
    input  logic s_clk,
    input  logic s_rst_n,
    input  logic incr,
    input  logic decr,
    output logic belowLimit,
    output logic isZero,
    output logic underflow
);

    logic [CNT_W-1:0] count;

    assign belowLimit = (count < CNT_W'(LIMIT));
    assign isZero     = (count == '0);

    // Credit count and sticky underflow flag.
    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            count     <= '0;
            underflow <= 1'b0;
        end else if (decr && isZero) begin
            // An unmatched return frees nothing; a same-cycle take still counts.
            underflow <= 1'b1;
            count     <= incr ? CNT_W'(1) : '0;
        end else if (incr && !decr) begin
            count <= count + CNT_W'(1);
        end else if (decr && !incr) begin
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/systolic_master_sender.sv
// Master-side spike packet sender: reads slices from the spike RAM and frames
// them on the MasterSend interface, metered by slave FIFO credits.
// Optional build macro SYS_SENDER_STALL_CNT_EN adds a credit-stall cycle counter.
module systolic_master_sender
    import systolic_master_sender_pkg::*;
#(
    parameter int DATA_WIDTH      = SYS_DATA_WIDTH,
    parameter int ADDR_WIDTH      = 12,
    parameter int SLICE_WORDS     = 16,
    parameter int SLICES_PER_LINE = SYS_SLICES_PER_LINE,
    parameter int NUM_LINES       = 4,
    parameter int MAX_CREDITS     = 4
) (
    input  logic                  s_clk,
    input  logic                  s_rst_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    output logic                  o_spk_rd_en,
    output logic [ADDR_WIDTH-1:0] o_spk_rd_addr,
    input  logic [DATA_WIDTH-1:0] i_spk_rd_data,
    output logic                  o_MasterSend_valid,
    output logic [DATA_WIDTH-1:0] o_MasterSend_data,
    output logic                  o_MasterSend_done,
    input  logic                  i_pkg_consumed,
    output logic                  o_line_sent,
    output logic                  o_busy,
    output logic                  o_job_done,
    output logic                  o_credit_err,
    output logic [15:0]           o_stall_cycles
);

    localparam int WORD_W  = cntWidth(SLICE_WORDS);
    localparam int SLICE_W = cntWidth(SLICES_PER_LINE);
    localparam int LINE_W  = cntWidth(NUM_LINES);

    senderState_t          state, nextState;
    logic [ADDR_WIDTH-1:0] runAddr;
    logic [WORD_W-1:0]     wordCnt;
    logic [SLICE_W-1:0]    sliceCnt;
    logic [LINE_W-1:0]     lineCnt;
    logic                  lastWord, lastSlice, lastLine;
    logic                  startAccept, sending;
    logic                  creditInc, belowLimit, creditZero, creditErr;
    logic                  jobDone;
    logic                  sendVld_p1, sendDone_p1, lineEnd_p1;

    assign lastWord    = (wordCnt == WORD_W'(SLICE_WORDS - 1));
    assign lastSlice   = (sliceCnt == SLICE_W'(SLICES_PER_LINE - 1));
    assign lastLine    = (lineCnt == LINE_W'(NUM_LINES - 1));
    assign startAccept = (state == S_IDLE) && i_start;
    assign sending     = (state == S_SEND);

    sender_credit_counter #(
        .CNT_W (CREDIT_W),
        .LIMIT (MAX_CREDITS)
    ) u_credit (
        .s_clk      (s_clk),
        .s_rst_n    (s_rst_n),
        .incr       (creditInc),
        .decr       (i_pkg_consumed),
        .belowLimit (belowLimit),
        .isZero     (creditZero),
        .underflow  (creditErr)
    );

    // State register.
    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) state <= S_IDLE;
        else          state <= nextState;
    end

    // Next state, credit take and job completion.
    always_comb begin
        nextState = state;
        creditInc = 1'b0;
        jobDone   = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_start) nextState = S_WAIT_CREDIT;
            end
            S_WAIT_CREDIT: begin
                if (belowLimit) begin
                    nextState = S_SEND;
                    creditInc = 1'b1;
                end
            end
            S_SEND: begin
                if (lastWord) nextState = (lastSlice && lastLine) ? S_DRAIN : S_WAIT_CREDIT;
            end
            S_DRAIN: begin
                if (creditZero && !sendVld_p1) begin
                    jobDone   = 1'b1;
                    nextState = S_IDLE;
                end
            end
            default: nextState = S_IDLE;
        endcase
    end

    // Running address plus word/slice/line position within the job.
    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            runAddr  <= '0;
            wordCnt  <= '0;
            sliceCnt <= '0;
            lineCnt  <= '0;
        end else if (startAccept) begin
            runAddr  <= i_base_addr;
            wordCnt  <= '0;
            sliceCnt <= '0;
            lineCnt  <= '0;
        end else if (sending) begin
            runAddr <= runAddr + ADDR_WIDTH'(1);
            if (!lastWord) begin
                wordCnt <= wordCnt + WORD_W'(1);
            end else begin
                wordCnt <= '0;
                if (!lastSlice) begin
                    sliceCnt <= sliceCnt + SLICE_W'(1);
                end else begin
                    sliceCnt <= '0;
                    if (!lastLine) lineCnt <= lineCnt + LINE_W'(1);
                end
            end
        end
    end

    // Stage p1: framing flags aligned with the RAM's one-cycle read latency.
    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            sendVld_p1  <= 1'b0;
            sendDone_p1 <= 1'b0;
            lineEnd_p1  <= 1'b0;
        end else begin
            sendVld_p1  <= sending;
            sendDone_p1 <= sending && lastWord;
            lineEnd_p1  <= sending && lastWord && lastSlice;
        end
    end

    assign o_spk_rd_en        = sending;
    assign o_spk_rd_addr      = runAddr;
    assign o_MasterSend_valid = sendVld_p1;
    assign o_MasterSend_data  = sendVld_p1 ? i_spk_rd_data : '0;
    assign o_MasterSend_done  = sendDone_p1;
    assign o_line_sent        = lineEnd_p1;
    assign o_busy             = (state != S_IDLE);
    assign o_job_done         = jobDone;
    assign o_credit_err       = creditErr;

`ifdef SYS_SENDER_STALL_CNT_EN
    logic [15:0] stallCnt;

    function automatic logic [15:0] satIncr16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Cycles blocked waiting for credit with the slave FIFO full.
    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n)                                     stallCnt <= '0;
        else if (startAccept)                             stallCnt <= '0;
        else if ((state == S_WAIT_CREDIT) && !belowLimit) stallCnt <= satIncr16(stallCnt);
    end

    assign o_stall_cycles = stallCnt;
`else
    assign o_stall_cycles = '0;
`endif

endmodule
